// File: rtl/clksw_seq_pkg.sv
// clksw_seq_pkg: shared constants for the CPU clock sequencer.
//   - state encoding (CLKSW_LS_RUN, CLKSW_HS_RUN, CLKSW_SYNC_LS)
//   - HS divider width
//   - CLKSW_TIMEOUT_ON: mirrors the CLKSW_TIMEOUT_EN build macro (default: disabled)
package clksw_seq_pkg;

  localparam int unsigned CLKSW_STATE_W = 2;
  localparam int unsigned CLKSW_DIV_W   = 2;

  localparam logic [CLKSW_STATE_W-1:0] CLKSW_LS_RUN  = 2'd0;
  localparam logic [CLKSW_STATE_W-1:0] CLKSW_HS_RUN  = 2'd1;
  localparam logic [CLKSW_STATE_W-1:0] CLKSW_SYNC_LS = 2'd2;

`ifdef CLKSW_TIMEOUT_EN
  localparam bit CLKSW_TIMEOUT_ON = 1'b1;
`else
  localparam bit CLKSW_TIMEOUT_ON = 1'b0;
`endif

endpackage

// File: rtl/clksw_sync.sv
// clksw_sync: STAGES-deep flop synchroniser, asynchronous active-low reset to 0.
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input
//   o_q      synchronised output (last stage)
module clksw_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clksw_seq.sv
// clksw_seq: glitch-free CPU clock sequencer running entirely in the hsclk domain.
// Chooses between a divided hsclk (HS) and a synchronised BBC 2MHz clock (LS) and drives the
// registered phi2 clock. Mode switches happen only at phase boundaries.
// Ports:
//   hsclk       sole clock
//   resetb      asynchronous active-low reset
//   lsclk_in    BBC phi0-derived clock, asynchronous to hsclk
//   srst_b      synchronous active-low soft reset, forces LS mode (keeps to_err)
//   hs_en       HS enable; when 0 hs_req is ignored
//   hs_req      HS clock request
//   hs_div_sel  HS half-period = hs_div_sel+1 hsclk cycles, sampled at phase reload
//   cpuclk_q    registered CPU phi2 clock
//   hs_active   1 while in HS_RUN
//   busy        1 while in SYNC_LS
//   to_err      sticky LS-resync timeout flag
// Build option: define CLKSW_TIMEOUT_EN to give SYNC_LS a TO_W-bit timeout that falls back to
// LS_RUN and sets to_err. Without it SYNC_LS waits for ls_fall indefinitely and to_err is 0.
module clksw_seq
  import clksw_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_W        = 6
) (
  input  logic                   hsclk,
  input  logic                   resetb,
  input  logic                   lsclk_in,
  input  logic                   srst_b,
  input  logic                   hs_en,
  input  logic                   hs_req,
  input  logic [CLKSW_DIV_W-1:0] hs_div_sel,
  output logic                   cpuclk_q,
  output logic                   hs_active,
  output logic                   busy,
  output logic                   to_err
);

  if (SYNC_STAGES < 2 || TO_W < 1) begin : g_param_chk
    $error("clksw_seq: SYNC_STAGES must be >= 2 and TO_W >= 1");
  end

  logic                     w_ls_s;
  logic                     w_ls_fall;
  logic                     w_req;
  logic                     r_ls_d;
  logic [CLKSW_STATE_W-1:0] r_state;
  logic [CLKSW_STATE_W-1:0] w_state_d;
  logic                     r_cpuclk;
  logic                     w_cpuclk_d;
  logic [CLKSW_DIV_W-1:0]   r_cnt;
  logic [CLKSW_DIV_W-1:0]   w_cnt_d;

  clksw_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (hsclk),
    .i_rst_n (resetb),
    .i_d     (lsclk_in),
    .o_q     (w_ls_s)
  );

  assign w_ls_fall = r_ls_d & ~w_ls_s;
  assign w_req     = hs_req & hs_en;

`ifdef CLKSW_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_inc;
  logic            w_to_hit;
  logic            r_to_err;

  assign w_to_inc = r_to_cnt + 1'b1;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_cpuclk_d = r_cpuclk;
    w_cnt_d    = r_cnt;
`ifdef CLKSW_TIMEOUT_EN
    w_to_hit   = 1'b0;
`endif
    case (r_state)
      CLKSW_LS_RUN: begin
        w_cpuclk_d = w_ls_s;
        // At ls_fall the LS clock has just gone low, so HS can start with a full low phase.
        if (w_req && w_ls_fall) begin
          w_state_d  = CLKSW_HS_RUN;
          w_cpuclk_d = 1'b0;
          w_cnt_d    = hs_div_sel;
        end
      end
      CLKSW_HS_RUN: begin
        if (r_cnt == '0) begin
          w_cpuclk_d = ~r_cpuclk;
          w_cnt_d    = hs_div_sel;
          // Request is only honoured at the start of a low phase.
          if (r_cpuclk && !w_req) begin
            w_state_d = CLKSW_SYNC_LS;
          end
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      CLKSW_SYNC_LS: begin
        w_cpuclk_d = 1'b0;
        if (w_ls_fall) begin
          w_state_d  = CLKSW_LS_RUN;
          w_cpuclk_d = w_ls_s;
        end
`ifdef CLKSW_TIMEOUT_EN
        else if (&w_to_inc) begin
          w_state_d  = CLKSW_LS_RUN;
          w_cpuclk_d = w_ls_s;
          w_to_hit   = 1'b1;
        end
`endif
      end
      default: begin
        w_state_d  = CLKSW_LS_RUN;
        w_cpuclk_d = 1'b0;
      end
    endcase
    if (!srst_b) begin
      w_state_d  = CLKSW_LS_RUN;
      w_cpuclk_d = 1'b0;
      w_cnt_d    = '0;
`ifdef CLKSW_TIMEOUT_EN
      w_to_hit   = 1'b0;
`endif
    end
  end

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_ls_d   <= 1'b0;
      r_state  <= CLKSW_LS_RUN;
      r_cpuclk <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_ls_d   <= w_ls_s;
      r_state  <= w_state_d;
      r_cpuclk <= w_cpuclk_d;
      r_cnt    <= w_cnt_d;
    end
  end

`ifdef CLKSW_TIMEOUT_EN
  // Counter sits at 0 outside SYNC_LS, so it is already clear on entry.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == CLKSW_SYNC_LS && srst_b) ? w_to_inc : '0;
      r_to_err <= r_to_err | w_to_hit;
    end
  end

  assign to_err = r_to_err;
`else
  assign to_err = 1'b0;
`endif

  assign cpuclk_q  = r_cpuclk;
  assign hs_active = (r_state == CLKSW_HS_RUN);
  assign busy      = (r_state == CLKSW_SYNC_LS);

endmodule

// File: doc/clksw_seq.md
Name: clksw_seq

Overview:
- Glitch-free CPU clock sequencer running entirely in the hsclk domain.
- Selects between a divided hsclk (HS mode) and a synchronised copy of the BBC 2MHz clock (LS mode).
- Generates the registered CPU phi2 clock and performs mode switches only at phase boundaries, so phi1 and phi2 are never shortened below one full phase.
- Sits between the address decode that produces the HS-select request and the cpu_ck_phi2 pin driver, replacing the current clock mux/divider.

Parameters:
- SYNC_STAGES, 2, number of flops in the lsclk_in synchroniser (minimum 2).
- TO_W, 6, width of the LS-resync timeout counter (used only with the optional feature).

Ports:
- hsclk  input  1  sole clock, high-speed oscillator; all state updates on its rising edge
- resetb  input  1  asynchronous active-low reset
- lsclk_in  input  1  BBC phi0-derived clock, asynchronous to hsclk
- srst_b  input  1  synchronous soft reset, active low; forces LS mode
- hs_en  input  1  map-register HS enable; when 0, hs_req is ignored
- hs_req  input  1  request for HS clock (decoded hsclk_sel)
- hs_div_sel  input  2  HS half-period = hs_div_sel+1 hsclk cycles
- cpuclk_q  output  1  registered CPU phi2 clock
- hs_active  output  1  1 while in HS_RUN
- busy  output  1  1 while in SYNC_LS
- to_err  output  1  sticky LS-resync timeout flag; tied 0 without the optional feature

Behaviour:
- lsclk_in passes through SYNC_STAGES flops to give ls_s, plus one more flop to give ls_d.
  - ls_fall = ls_d & !ls_s.
- States: LS_RUN, HS_RUN, SYNC_LS. Encoding is internal.
- Reset (resetb=0 or srst_b=0):
  - state=LS_RUN, cpuclk_q=0, phase counter=0, hs_active=0, busy=0, to_err=0.
  - srst_b does not clear to_err.
- LS_RUN:
  - cpuclk_q <= ls_s, giving a fixed latency of SYNC_STAGES+1 hsclk cycles from lsclk_in.
  - If hs_en & hs_req on a cycle with ls_fall: state <= HS_RUN, cpuclk_q <= 0, counter loads hs_div_sel, and HS starts with a low phase.
- HS_RUN:
  - Counter decrements each cycle. At 0, cpuclk_q toggles and the counter reloads from the current hs_div_sel.
  - hs_div_sel is sampled only at reload. A mid-phase change never alters the current phase length.
  - On a 1->0 toggle, (hs_req & hs_en) is sampled. If 0: state <= SYNC_LS, cpuclk_q held 0.
  - The request is never acted on during a high phase.
- SYNC_LS:
  - cpuclk_q held 0.
  - On ls_fall: state <= LS_RUN, and cpuclk_q then follows ls_s, which is low at entry.
  - If hs_req & hs_en reasserts during SYNC_LS, the state still completes to LS_RUN first. There is no direct SYNC_LS->HS_RUN transition.
- Simultaneous events:
  - ls_fall and a request change in LS_RUN: the request value in that same cycle decides.
  - srst_b overrides all transitions.
- hs_en=0: forces the same effect as hs_req=0, with switch-out only at the next HS low-phase start.
- Guaranteed minimum CPU low phase at any switch is max(1 hsclk cycle, one HS half-period).
- Outputs:
  - hs_active = (state==HS_RUN).
  - busy = (state==SYNC_LS).

Optional Feature:
- Macro: CLKSW_TIMEOUT_EN.
- Enabled:
  - A TO_W-bit counter clears on entry to SYNC_LS and increments each cycle there.
  - On reaching all-ones without ls_fall: state <= LS_RUN, cpuclk_q follows ls_s, and to_err is set.
  - to_err is sticky and cleared only by resetb.
- Disabled:
  - No counter. SYNC_LS waits indefinitely. to_err is tied 0.

Decomposition:
- Shared package holds:
  - state encoding constants (CLKSW_LS_RUN, CLKSW_HS_RUN, CLKSW_SYNC_LS);
  - the 2-bit divider width constant;
  - the CLKSW_TIMEOUT_EN default.
- One sub-module: clksw_sync, the parameterised SYNC_STAGES synchroniser with async reset to 0. The edge detect stays in the parent.

Test Plan:
- Reset: resetb=0 with lsclk_in toggling -> cpuclk_q=0, hs_active=0. After release, cpuclk_q tracks lsclk_in delayed 3 hsclk cycles.
- LS->HS: hs_en=1, hs_req=1, hs_div_sel=1 -> HS_RUN entered on the first ls_fall; cpuclk_q low 2 cycles, high 2, repeating; no phase shorter than 2 cycles.
- HS->LS: drop hs_req mid high phase -> high phase completes, busy=1 until the next ls_fall, then cpuclk_q follows ls_s; no high pulse shorter than one LS half-period.
- Divider change: change hs_div_sel 1->3 mid phase -> the current phase stays 2 cycles, the next phase is 4 cycles.
- srst_b pulse during HS_RUN -> the next cycle is LS_RUN with cpuclk_q=0; to_err is unchanged.
- CLKSW_TIMEOUT_EN with TO_W=6: stop lsclk_in, then drop hs_req -> after 63 cycles in SYNC_LS, state is LS_RUN and to_err=1. Without the macro, busy stays 1 indefinitely.
